// File: rtl/mbus_pkg.sv
// Shared types and helpers for the mbus memory responder: FSM state encodings
// and the byte-address to word-offset mapping used by both request channels.
package mbus_pkg;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_WAIT = 2'd1,
        RD_RESP = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        WR_IDLE   = 2'd0,
        WR_WAIT_W = 2'd1,
        WR_BRESP  = 2'd2
    } wr_state_e;

    localparam int unsigned MBUS_BYTE_W = 8;

    function automatic int unsigned bytes_per_word(input int unsigned data_width);
        return data_width / MBUS_BYTE_W;
    endfunction

    // Unbounded word offset; callers truncate to the array index or range-check it.
    function automatic logic [63:0] word_offset(input logic [63:0] addr,
                                                input logic [63:0] base,
                                                input int unsigned lg_bpw);
        return (addr - base) >> lg_bpw;
    endfunction

endpackage

// File: rtl/mbus_wdata_fifo.sv
// Synchronous FIFO buffering {strb, data} w beats until the write FSM pairs
// them with an aw. A push while full is accepted only alongside a pop.
module mbus_wdata_fifo #(
    parameter int WIDTH      = 36,
    parameter int DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]   count_q, count_d;
    logic                  push_ok, pop_ok;

    assign full     = (count_q == (DEPTH_BITS+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + DEPTH_BITS'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + DEPTH_BITS'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + (DEPTH_BITS+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (DEPTH_BITS+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/mbus_mem_responder.sv
// Memory-side mbus target: single-beat reads and strobed single-beat writes
// into an on-chip word array. Range checking and error responses: MBUS_RESP_ERR_EN.
module mbus_mem_responder
    import mbus_pkg::*;
#(
    parameter int                         MBUS_DATA_WIDTH  = 32,
    parameter int                         MBUS_ADDR_WIDTH  = 32,
    parameter int                         MEM_DEPTH_BITS   = 12,
    parameter logic [MBUS_ADDR_WIDTH-1:0] MEM_BASE         = '0,
    parameter int                         RD_LATENCY       = 1,
    parameter int                         WFIFO_DEPTH_BITS = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [MBUS_ADDR_WIDTH-1:0]   mbus_ar_addr,
    input  logic                         mbus_ar_valid,
    output logic                         mbus_ar_ready,
    output logic [MBUS_DATA_WIDTH-1:0]   mbus_r_data,
    output logic                         mbus_r_valid,
    input  logic                         mbus_r_ready,
    input  logic [MBUS_ADDR_WIDTH-1:0]   mbus_aw_addr,
    input  logic                         mbus_aw_valid,
    output logic                         mbus_aw_ready,
    input  logic [MBUS_DATA_WIDTH-1:0]   mbus_w_data,
    input  logic                         mbus_w_valid,
    input  logic [MBUS_DATA_WIDTH/8-1:0] mbus_w_strb,
    output logic                         mbus_b_resp,
    output logic                         mbus_b_valid,
    input  logic                         mbus_b_ready,
    output logic                         wr_overflow
);

    localparam int unsigned BPW    = bytes_per_word(MBUS_DATA_WIDTH);
    localparam int unsigned LG_BPW = $clog2(BPW);
    localparam int          DEPTH  = 1 << MEM_DEPTH_BITS;
    localparam int          CNT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam int          FIFO_W = MBUS_DATA_WIDTH + MBUS_DATA_WIDTH/8;

    logic [MBUS_DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [MEM_DEPTH_BITS-1:0]    ar_idx, aw_idx;
    rd_state_e                    rd_state_q, rd_state_d;
    logic [CNT_W-1:0]             rd_cnt_q, rd_cnt_d;
    logic [MBUS_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                         ar_ready_int, r_valid_int;

    wr_state_e                    wr_state_q, wr_state_d;
    logic [MEM_DEPTH_BITS-1:0]    wr_idx_q, wr_idx_d;
    logic                         wr_overflow_q, wr_overflow_d;
    logic                         aw_ready_int, b_valid_int, wr_commit;

    logic                         fifo_pop, fifo_full, fifo_empty;
    logic [FIFO_W-1:0]            fifo_rdata;
    logic [MBUS_DATA_WIDTH-1:0]   w_data_h;
    logic [MBUS_DATA_WIDTH/8-1:0] w_strb_h;

    // Without range checking the index simply wraps over the array.
    assign ar_idx = MEM_DEPTH_BITS'(word_offset(64'(mbus_ar_addr), 64'(MEM_BASE), LG_BPW));
    assign aw_idx = MEM_DEPTH_BITS'(word_offset(64'(mbus_aw_addr), 64'(MEM_BASE), LG_BPW));

`ifdef MBUS_RESP_ERR_EN
    logic ar_oor, aw_oor;
    logic wr_err_q, wr_err_d;

    assign ar_oor = (64'(mbus_ar_addr) < 64'(MEM_BASE)) ||
                    (word_offset(64'(mbus_ar_addr), 64'(MEM_BASE), LG_BPW) >= 64'(DEPTH));
    assign aw_oor = (64'(mbus_aw_addr) < 64'(MEM_BASE)) ||
                    (word_offset(64'(mbus_aw_addr), 64'(MEM_BASE), LG_BPW) >= 64'(DEPTH));
`endif

    mbus_wdata_fifo #(
        .WIDTH      (FIFO_W),
        .DEPTH_BITS (WFIFO_DEPTH_BITS)
    ) u_wfifo (
        .clk       (clk),
        .reset     (reset),
        .push      (mbus_w_valid),
        .push_data ({mbus_w_strb, mbus_w_data}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign {w_strb_h, w_data_h} = fifo_rdata;

    always_comb begin
        rd_state_d   = rd_state_q;
        rd_cnt_d     = rd_cnt_q;
        rdata_d      = rdata_q;
        ar_ready_int = 1'b0;
        r_valid_int  = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                ar_ready_int = 1'b1;
                if (mbus_ar_valid) begin
                    // Sampling the array before a same-cycle commit lands gives read-before-write.
                    rdata_d = mem_q[ar_idx];
`ifdef MBUS_RESP_ERR_EN
                    if (ar_oor) begin
                        rdata_d = '0;
                    end
`endif
                    rd_cnt_d = CNT_W'(RD_LATENCY - 1);
                    if (RD_LATENCY == 1) begin
                        rd_state_d = RD_RESP;
                    end else begin
                        rd_state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                rd_cnt_d = rd_cnt_q - CNT_W'(1);
                if (rd_cnt_q == CNT_W'(1)) begin
                    rd_state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                r_valid_int = 1'b1;
                if (mbus_r_ready) begin
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        wr_state_d    = wr_state_q;
        wr_idx_d      = wr_idx_q;
        aw_ready_int  = 1'b0;
        b_valid_int   = 1'b0;
        fifo_pop      = 1'b0;
        wr_commit     = 1'b0;
`ifdef MBUS_RESP_ERR_EN
        wr_err_d      = wr_err_q;
`endif
        wr_overflow_d = wr_overflow_q;
        case (wr_state_q)
            WR_IDLE: begin
                aw_ready_int = 1'b1;
                if (mbus_aw_valid) begin
                    wr_idx_d   = aw_idx;
`ifdef MBUS_RESP_ERR_EN
                    wr_err_d   = aw_oor;
`endif
                    wr_state_d = WR_WAIT_W;
                end
            end
            WR_WAIT_W: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
`ifdef MBUS_RESP_ERR_EN
                    wr_commit  = !wr_err_q;
`else
                    wr_commit  = 1'b1;
`endif
                    wr_state_d = WR_BRESP;
                end
            end
            WR_BRESP: begin
                b_valid_int = 1'b1;
                if (mbus_b_ready) begin
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
        if (mbus_w_valid && fifo_full && !fifo_pop) begin
            wr_overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_q    <= RD_IDLE;
            rd_cnt_q      <= '0;
            rdata_q       <= '0;
            wr_state_q    <= WR_IDLE;
            wr_idx_q      <= '0;
            wr_overflow_q <= 1'b0;
        end else begin
            rd_state_q    <= rd_state_d;
            rd_cnt_q      <= rd_cnt_d;
            rdata_q       <= rdata_d;
            wr_state_q    <= wr_state_d;
            wr_idx_q      <= wr_idx_d;
            wr_overflow_q <= wr_overflow_d;
        end
    end

`ifdef MBUS_RESP_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_err_d;
        end
    end
`endif

    // Contents survive reset; a commit coinciding with reset is abandoned.
    always_ff @(posedge clk) begin
        if (wr_commit && !reset) begin
            for (int b = 0; b < MBUS_DATA_WIDTH/8; b++) begin
                if (w_strb_h[b]) begin
                    mem_q[wr_idx_q][b*8 +: 8] <= w_data_h[b*8 +: 8];
                end
            end
        end
    end

    assign mbus_ar_ready = ar_ready_int && !reset;
    assign mbus_r_valid  = r_valid_int && !reset;
    assign mbus_r_data   = reset ? '0 : rdata_q;
    assign mbus_aw_ready = aw_ready_int && !reset;
    assign mbus_b_valid  = b_valid_int && !reset;
`ifdef MBUS_RESP_ERR_EN
    assign mbus_b_resp   = b_valid_int && wr_err_q && !reset;
`else
    assign mbus_b_resp   = 1'b0;
`endif
    assign wr_overflow   = wr_overflow_q && !reset;

endmodule

// File: tb/tb_mbus_mem_responder.sv
// Directed bench for mbus_mem_responder built with RD_LATENCY=3; the
// out-of-range section follows MBUS_RESP_ERR_EN.
module tb_mbus_mem_responder;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] ar_addr, aw_addr;
    logic          ar_valid, ar_ready;
    logic [DW-1:0] r_data;
    logic          r_valid, r_ready;
    logic          aw_valid, aw_ready;
    logic [DW-1:0] w_data;
    logic          w_valid;
    logic [3:0]    w_strb;
    logic          b_resp, b_valid, b_ready;
    logic          ovf;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];

    mbus_mem_responder #(
        .MBUS_DATA_WIDTH  (DW),
        .MBUS_ADDR_WIDTH  (AW),
        .MEM_DEPTH_BITS   (12),
        .MEM_BASE         (32'h0000_0000),
        .RD_LATENCY       (3),
        .WFIFO_DEPTH_BITS (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mbus_ar_addr  (ar_addr),
        .mbus_ar_valid (ar_valid),
        .mbus_ar_ready (ar_ready),
        .mbus_r_data   (r_data),
        .mbus_r_valid  (r_valid),
        .mbus_r_ready  (r_ready),
        .mbus_aw_addr  (aw_addr),
        .mbus_aw_valid (aw_valid),
        .mbus_aw_ready (aw_ready),
        .mbus_w_data   (w_data),
        .mbus_w_valid  (w_valid),
        .mbus_w_strb   (w_strb),
        .mbus_b_resp   (b_resp),
        .mbus_b_valid  (b_valid),
        .mbus_b_ready  (b_ready),
        .wr_overflow   (ovf)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // aw and w in the same cycle, b_ready high: b_valid must appear two cycles later.
    task automatic write_same_cycle(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                    input logic [3:0] strb, input logic exp_resp);
        check("aw_ready_idle", aw_ready, 1);
        aw_addr = addr; aw_valid = 1; w_data = data; w_strb = strb; w_valid = 1; b_ready = 1;
        tick();
        aw_valid = 0; w_valid = 0;
        check("b_valid_n1", b_valid, 0);
        tick();
        check("b_valid_n2", b_valid, 1);
        check("b_resp", b_resp, exp_resp);
        tick();
        check("b_valid_done", b_valid, 0);
    endtask

    task automatic push_w(input logic [DW-1:0] data, input logic [3:0] strb);
        w_data = data; w_strb = strb; w_valid = 1;
        tick();
        w_valid = 0;
    endtask

    // aw alone against already-buffered w beats, with b held off for 'hold' cycles.
    task automatic send_aw(input logic [AW-1:0] addr, input int hold);
        int c;
        check("aw_ready_before", aw_ready, 1);
        aw_addr = addr; aw_valid = 1; b_ready = 0;
        tick();
        aw_valid = 0;
        c = 0;
        while (!b_valid && c < 10) begin
            tick();
            c++;
        end
        check("b_wait_cycles", c, 1);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("b_valid_held", b_valid, 1);
            check("aw_ready_busy", aw_ready, 0);
        end
        b_ready = 1;
        tick();
        b_ready = 0;
        check("b_valid_clear", b_valid, 0);
    endtask

    // Single read; expected data comes from the front of exp_q.
    task automatic do_read(input logic [AW-1:0] addr, input int hold);
        int lat;
        logic [DW-1:0] exp;
        exp = exp_q.pop_front();
        check("ar_ready_before", ar_ready, 1);
        ar_addr = addr; ar_valid = 1; r_ready = (hold == 0);
        tick();
        ar_valid = 0;
        lat = 1;
        while (!r_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("r_latency", lat, 3);
        check("r_data", r_data, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("r_valid_held", r_valid, 1);
            check("r_data_stable", r_data, exp);
        end
        r_ready = 1;
        tick();
        r_ready = 0;
        check("r_valid_clear", r_valid, 0);
    endtask

    initial begin
        int c;
        reset = 1; ar_addr = 0; ar_valid = 0; r_ready = 0; aw_addr = 0; aw_valid = 0;
        w_data = 0; w_valid = 0; w_strb = 0; b_ready = 0;

        // Reset and idle
        repeat (3) tick();
        check("rst_ar_ready", ar_ready, 0);
        check("rst_aw_ready", aw_ready, 0);
        check("rst_r_valid", r_valid, 0);
        check("rst_r_data", r_data, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_b_resp", b_resp, 0);
        check("rst_overflow", ovf, 0);
        reset = 0;
        tick();
        check("idle_ar_ready", ar_ready, 1);
        check("idle_aw_ready", aw_ready, 1);
        check("idle_r_valid", r_valid, 0);
        check("idle_b_valid", b_valid, 0);

        // Full write then read
        write_same_cycle(32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
        exp_q.push_back(32'hDEAD_BEEF);
        do_read(32'h10, 0);

        // Partial strobe: bytes 0 and 2 replaced
        write_same_cycle(32'h10, 32'h1122_3344, 4'b0101, 1'b0);
        exp_q.push_back(32'hDE22_BE44);
        do_read(32'h10, 2);

        // w beats ahead of aw, b backpressured, in-order pairing
        push_w(32'hA000_0001, 4'hF);
        push_w(32'hA000_0002, 4'hF);
        push_w(32'hA000_0003, 4'hF);
        check("ovf_after3", ovf, 0);
        send_aw(32'h20, 2);
        send_aw(32'h24, 0);
        send_aw(32'h28, 1);
        exp_q.push_back(32'hA000_0001);
        exp_q.push_back(32'hA000_0002);
        exp_q.push_back(32'hA000_0003);
        do_read(32'h20, 0);
        do_read(32'h24, 0);
        do_read(32'h28, 0);

        // Overflow: fifth beat with depth 4 and no pop is dropped
        push_w(32'hC000_0000, 4'hF);
        push_w(32'hC000_0001, 4'hF);
        push_w(32'hC000_0002, 4'hF);
        push_w(32'hC000_0003, 4'hF);
        check("ovf_after4", ovf, 0);
        push_w(32'hC000_0004, 4'hF);
        check("ovf_after5", ovf, 1);
        send_aw(32'h40, 0);
        send_aw(32'h44, 0);
        send_aw(32'h48, 0);
        send_aw(32'h4C, 0);
        exp_q.push_back(32'hC000_0000);
        exp_q.push_back(32'hC000_0003);
        do_read(32'h40, 0);
        do_read(32'h4C, 0);
        check("ovf_sticky", ovf, 1);

        // Collision: ar handshake in the same cycle as the commit sees the old word
        write_same_cycle(32'h30, 32'hAAAA_0000, 4'hF, 1'b0);
        aw_addr = 32'h30; aw_valid = 1; w_data = 32'h5555_5555; w_strb = 4'hF; w_valid = 1;
        b_ready = 1;
        tick();
        aw_valid = 0; w_valid = 0;
        check("coll_ar_ready", ar_ready, 1);
        ar_addr = 32'h30; ar_valid = 1; r_ready = 1;
        tick();
        ar_valid = 0;
        check("coll_b_valid", b_valid, 1);
        c = 0;
        while (!r_valid && c < 20) begin
            tick();
            c++;
        end
        check("coll_r_wait", c, 2);
        check("coll_r_data_old", r_data, 32'hAAAA_0000);
        tick();
        r_ready = 0;
        check("coll_r_clear", r_valid, 0);
        exp_q.push_back(32'h5555_5555);
        do_read(32'h30, 0);

        // Address beyond the array
        write_same_cycle(32'h0, 32'h0BAD_F00D, 4'hF, 1'b0);
`ifdef MBUS_RESP_ERR_EN
        write_same_cycle(32'h4000, 32'hCAFE_F00D, 4'hF, 1'b1);
        exp_q.push_back(32'h0BAD_F00D);
        exp_q.push_back(32'h0000_0000);
`else
        write_same_cycle(32'h4000, 32'hCAFE_F00D, 4'hF, 1'b0);
        exp_q.push_back(32'hCAFE_F00D);
        exp_q.push_back(32'hCAFE_F00D);
`endif
        do_read(32'h0, 0);
        do_read(32'h4000, 0);

        // Reset during an outstanding read abandons it and clears the overflow flag
        ar_addr = 32'h10; ar_valid = 1; r_ready = 0;
        tick();
        ar_valid = 0;
        reset = 1;
        tick();
        check("mid_rst_r_valid", r_valid, 0);
        check("mid_rst_ar_ready", ar_ready, 0);
        check("mid_rst_overflow", ovf, 0);
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_no_r", r_valid, 0);
        end
        check("post_rst_ar_ready", ar_ready, 1);
        check("post_rst_overflow", ovf, 0);

        check("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
